// File: rtl/design205_stim_seq.sv
// design205_stim_seq: sequences DUT reset, LFSR random vectors, a second reset and a
// directed vector, with a sample strobe on the last hold cycle of each step.
module design205_stim_seq #(
  parameter int          WIDTH      = 32,
  parameter int          NUM_RANDOM = 1000,
  parameter int          HOLD       = 2,
  parameter logic [31:0] SEED       = 32'h00000001,
  parameter logic [31:0] DIRECTED   = 32'habcdefab
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_rst,
  output logic [WIDTH-1:0] dut_in,
  output logic             sample,
  output logic [2:0]       phase,
  output logic [15:0]      vec_count,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] IDLE = 3'd0, RST1 = 3'd1, REL1 = 3'd2, RAND = 3'd3;
  localparam logic [2:0] RST2 = 3'd4, REL2 = 3'd5, DIR = 3'd6, DONE = 3'd7;
  localparam logic [31:0] MASK = 32'h80200003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [3:0] LAST = 4'(HOLD - 1);
  localparam logic [15:0] NRAND = 16'(NUM_RANDOM);
  localparam logic [WIDTH-1:0] DIR_VEC = DIRECTED[WIDTH-1:0];
  logic [2:0] phase_n;
  logic [3:0] hold, hold_n;
  logic [31:0] lfsr, lfsr_n;
  logic [15:0] vc_n;
  logic held, held_n, last;
  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? MASK : 32'h0);
  endfunction
  assign held = phase inside {RST1, RAND, RST2, DIR};
  assign held_n = phase_n inside {RST1, RAND, RST2, DIR};
  assign last = hold == LAST;
  // Outputs are registered from next-state values so they line up with phase.
  always_comb begin
    phase_n = phase;
    lfsr_n = lfsr;
    vc_n = vec_count;
    hold_n = (held && !last) ? hold + 4'd1 : 4'd0;
    case (phase)
      IDLE, DONE: if (start) begin
        phase_n = RST1;
        lfsr_n = SEED_EFF;
        vc_n = '0;
      end
      RST1: phase_n = last ? REL1 : RST1;
      REL1: begin
        phase_n = RAND;
        lfsr_n = step(lfsr);
      end
      RAND: if (last) begin
        vc_n = vec_count + 16'd1;
        phase_n = (vc_n == NRAND) ? RST2 : RAND;
        lfsr_n = (vc_n == NRAND) ? lfsr : step(lfsr);
      end
      RST2: phase_n = last ? REL2 : RST2;
      REL2: phase_n = DIR;
      default: phase_n = last ? DONE : DIR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= IDLE;
      hold <= '0;
      lfsr <= SEED_EFF;
      vec_count <= '0;
      dut_rst <= 1'b1;
      dut_in <= '0;
      sample <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      phase <= phase_n;
      hold <= hold_n;
      lfsr <= lfsr_n;
      vec_count <= vc_n;
      dut_rst <= phase_n inside {IDLE, RST1, RST2};
      dut_in <= (phase_n == RAND) ? lfsr_n[WIDTH-1:0] : (phase_n inside {DIR, DONE}) ? DIR_VEC : '0;
      sample <= held_n && (hold_n == LAST);
      busy <= phase_n inside {[RST1:DIR]};
      done <= phase_n == DONE;
    end
  end
endmodule

// File: tb/tb_design205_stim_seq.sv
// tb_design205_stim_seq: random-start checks of the stimulus sequencer against a
// per-cycle trace built from the sequencing rules.
module tb_design205_stim_seq;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start0 = 1'b0, start_s = 1'b0;
  always #5 clk = ~clk;

  logic dut_rst, sample, busy, done;
  logic [31:0] dut_in;
  logic [2:0] phase;
  logic [15:0] vec_count;
  logic d0_rst, d0_sample, d0_busy, d0_done;
  logic [31:0] d0_in;
  logic [2:0] d0_phase;
  logic [15:0] d0_count;
  logic s_rst, s_sample, s_busy, s_done;
  logic [7:0] s_in;
  logic [2:0] s_phase;
  logic [15:0] s_count;

  design205_stim_seq dut (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst), .dut_in(dut_in), .sample(sample),
    .phase(phase), .vec_count(vec_count), .busy(busy), .done(done));
  design205_stim_seq #(.SEED(32'h0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_rst(d0_rst), .dut_in(d0_in), .sample(d0_sample),
    .phase(d0_phase), .vec_count(d0_count), .busy(d0_busy), .done(d0_done));
  design205_stim_seq #(.WIDTH(8), .NUM_RANDOM(1), .HOLD(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .dut_rst(s_rst), .dut_in(s_in), .sample(s_sample),
    .phase(s_phase), .vec_count(s_count), .busy(s_busy), .done(s_done));

  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0]  ph;
    logic        r;
    logic [31:0] v;
    logic        s;
  } ent_t;
  ent_t tr[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Expected outputs for every cycle from the first RST1 cycle through the first DONE cycle.
  task automatic build_trace(input int n, input int h, input logic [31:0] seed, input logic [31:0] dir);
    logic [31:0] v;
    v = (seed == 32'h0) ? 32'h1 : seed;
    tr.delete();
    for (int c = 0; c < h; c++) tr.push_back('{3'd1, 1'b1, 32'h0, c == h - 1});
    tr.push_back('{3'd2, 1'b0, 32'h0, 1'b0});
    for (int k = 0; k < n; k++) begin
      v = lfsr_next(v);
      for (int c = 0; c < h; c++) tr.push_back('{3'd3, 1'b0, v, c == h - 1});
    end
    for (int c = 0; c < h; c++) tr.push_back('{3'd4, 1'b1, 32'h0, c == h - 1});
    tr.push_back('{3'd5, 1'b0, 32'h0, 1'b0});
    for (int c = 0; c < h; c++) tr.push_back('{3'd6, 1'b0, dir, c == h - 1});
    tr.push_back('{3'd7, 1'b0, dir, 1'b0});
  endtask

  task automatic walk_default(input string nm);
    int busyc, smpc;
    busyc = 0;
    smpc = 0;
    build_trace(1000, 2, 32'h1, 32'habcdefab);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (vec_count !== 16'd0) begin
      errors++;
      $display("FAIL %s vec_count_at_start got %0d want 0", nm, vec_count);
    end
    foreach (tr[i]) begin
      checks++;
      if ({phase, dut_rst, dut_in, sample, busy, done} !==
          {tr[i].ph, tr[i].r, tr[i].v, tr[i].s, tr[i].ph inside {[3'd1:3'd6]}, tr[i].ph == 3'd7}) begin
        errors++;
        if (errors < 20)
          $display("FAIL %s cycle %0d got ph=%0d rst=%b in=%h smp=%b busy=%b done=%b want ph=%0d rst=%b in=%h smp=%b",
                   nm, i, phase, dut_rst, dut_in, sample, busy, done, tr[i].ph, tr[i].r, tr[i].v, tr[i].s);
      end
      busyc += int'(busy);
      smpc += int'(sample);
      start = (i < tr.size() - 1) && ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busyc != 2 * (2 + 1) + 1000 * 2 + 2) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want 2008", nm, busyc);
    end
    checks++;
    if (smpc != 1000 + 3) begin
      errors++;
      $display("FAIL %s sample_count got %0d want 1003", nm, smpc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom_range(0, 1));
      start_s = start;
      @(negedge clk);
      checks++;
      if ({phase, dut_rst, dut_in, sample, busy, done, vec_count} !== {3'd0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0} ||
          {s_phase, s_rst, s_in, s_sample, s_busy, s_done} !== {3'd0, 1'b1, 8'h0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset cycle %0d got ph=%0d rst=%b in=%h smp=%b busy=%b done=%b want ph=0 rst=1 in=0 smp=0 busy=0 done=0",
                 i, phase, dut_rst, dut_in, sample, busy, done);
      end
    end
    start = 1'b0;
    start_s = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_corner();
    int busyc, smpc;
    busyc = 0;
    smpc = 0;
    build_trace(1, 1, 32'h1, 32'habcdefab);
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    foreach (tr[i]) begin
      checks++;
      if ({s_phase, s_rst, s_in, s_sample, s_busy, s_done} !==
          {tr[i].ph, tr[i].r, tr[i].v[7:0], tr[i].s, tr[i].ph inside {[3'd1:3'd6]}, tr[i].ph == 3'd7}) begin
        errors++;
        $display("FAIL corner cycle %0d got ph=%0d rst=%b in=%h smp=%b want ph=%0d rst=%b in=%h smp=%b",
                 i, s_phase, s_rst, s_in, s_sample, tr[i].ph, tr[i].r, tr[i].v[7:0], tr[i].s);
      end
      busyc += int'(s_busy);
      smpc += int'(s_sample);
      start_s = (i < tr.size() - 1) && (i == 2 || $urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start_s = 1'b0;
    checks++;
    if (busyc != 6 || smpc != 4 || s_count !== 16'd1 || s_in !== 8'hab) begin
      errors++;
      $display("FAIL corner_totals got busy=%0d smp=%0d cnt=%0d in=%h want busy=6 smp=4 cnt=1 in=ab",
               busyc, smpc, s_count, s_in);
    end
  endtask

  task automatic test_sequence();
    walk_default("sequence");
  endtask

  task automatic test_directed_done();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({done, busy, vec_count, dut_in, phase, sample} !== {1'b1, 1'b0, 16'd1000, 32'habcdefab, 3'd7, 1'b0}) begin
        errors++;
        $display("FAIL done_hold cycle %0d got done=%b busy=%b cnt=%0d in=%h ph=%0d want done=1 busy=0 cnt=1000 in=abcdefab ph=7",
                 i, done, busy, vec_count, dut_in, phase);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_restart();
    walk_default("restart");
    test_directed_done();
  endtask

  task automatic test_seed0();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (d0_phase !== 3'd3 || d0_in !== 32'h80200003) begin
      errors++;
      $display("FAIL seed0_first_vector got ph=%0d in=%h want ph=3 in=80200003", d0_phase, d0_in);
    end
  endtask

  task automatic test_midrun_reset();
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (vec_count !== 16'd500 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000 || phase !== 3'd3) begin
      errors++;
      $display("FAIL midrun_wait got n=%0d ph=%0d want vec_count 500 in phase 3", n, phase);
    end
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({phase, dut_rst, dut_in, vec_count, sample, busy, done} !==
          {3'd0, 1'b1, 32'h0, 16'd0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL midrun_reset cycle %0d got ph=%0d rst=%b in=%h cnt=%0d smp=%b busy=%b want idle",
                 i, phase, dut_rst, dut_in, vec_count, sample, busy);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    walk_default("replay");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_corner();
    test_sequence();
    test_directed_done();
    test_restart();
    test_seed0();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/design205_stim_seq.md
Name: design205_stim_seq

Overview:
- Synthesizable stimulus sequencer that sits directly upstream of design205_55_50_top and its post-synth netlist.
- Generates the reset phase, pseudo-random vectors, a second reset, and a directed vector, in the fixed order the co-sim flow needs.
- Drives a shared dut_rst/dut_in to both DUT instances and emits a sample strobe that tells the downstream comparator when outputs are valid.
- Lets the same check run on hardware (FPGA) without a behavioural testbench.

Parameters:
WIDTH, 32, data width of dut_in; legal range 1..32; lfsr[WIDTH-1:0] is driven
NUM_RANDOM, 1000, number of random vectors; legal range 1..65535
HOLD, 2, cycles each vector/reset is held; legal range 1..15; sample fires on the last hold cycle
SEED, 32'h00000001, LFSR load value; 0 is replaced by 32'h00000001
DIRECTED, 32'habcdefab, final directed vector (low WIDTH bits used)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  one-cycle pulse that begins a sequence; ignored while busy=1
dut_rst  output  1  active-high reset to both DUT instances
dut_in  output  WIDTH  stimulus to both DUT instances
sample  output  1  one-cycle pulse: downstream compares golden vs netlist this cycle
phase  output  3  encoded FSM state: IDLE=0, RST1=1, REL1=2, RAND=3, RST2=4, REL2=5, DIR=6, DONE=7
vec_count  output  16  random vectors completed (saturates at NUM_RANDOM)
busy  output  1  high in states RST1..DIR
done  output  1  high in DONE, sticky until next start or reset

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge):
  - phase=IDLE, dut_rst=1, dut_in=0, sample=0, vec_count=0, busy=0, done=0.
  - LFSR reloads SEED.
  - Reset mid-sequence aborts immediately; no partial sample is emitted.
- Hold counter: counts 0..HOLD-1 in RST1, RAND, RST2, DIR. sample=1 exactly when it equals HOLD-1.
- State transitions:
  - IDLE: dut_rst=1, dut_in=0. On start → RST1, hold counter cleared.
  - RST1: dut_rst=1, dut_in=0 for HOLD cycles, sample on the last; then → REL1.
  - REL1: one cycle, dut_rst=0, dut_in=0, no sample; → RAND.
  - RAND: dut_rst=0, dut_in=lfsr[WIDTH-1:0], held HOLD cycles, sample on the last. In that last cycle the LFSR advances and vec_count increments. When vec_count reaches NUM_RANDOM → RST2.
  - RST2: as RST1 (dut_in forced 0); then → REL2.
  - REL2: as REL1; → DIR.
  - DIR: dut_in=DIRECTED, HOLD cycles, sample on the last; → DONE.
  - DONE: done=1, busy=0, dut_rst=0, dut_in holds DIRECTED. start → RST1.
- Restart from DONE: LFSR reloads SEED and vec_count clears, so every run is bit-identical.
- LFSR:
  - 32-bit right-shift Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
  - Next state = (s>>1) ^ (s[0] ? mask : 0).
  - It advances only at the end of each RAND vector.
  - The first random vector is the first advanced state, not SEED.
- Cycle and sample counts: busy cycles per run = 2*(HOLD+1) + NUM_RANDOM*HOLD + HOLD. Samples per run = NUM_RANDOM + 3.
- start during busy is ignored. start asserted in the same cycle as rst=0 is ignored (reset wins).
- dut_in changes only at vector boundaries, and changes one cycle before the DUT clock edge that captures it.

Test Plan:
- Reset value: hold rst=0 5 cycles with start toggling → phase=0, dut_rst=1, dut_in=0, sample=0, busy=0, done=0 throughout.
- Sequence order and timing (defaults):
  - Pulse start; RST1 lasts 2 cycles with sample on the 2nd; REL1 lasts 1 cycle.
  - First RAND vector: dut_in=32'h80200003 for 2 cycles; second vector: 32'hC0300002.
  - busy high for exactly 2008 cycles; 1003 sample pulses total.
- Directed and done: after the run, DIR shows dut_in=32'hABCDEFAB with one sample; then done=1, vec_count=1000, dut_in stays 32'hABCDEFAB.
- Restart determinism: pulse start from DONE → first RAND vector is again 32'h80200003 and vec_count restarts at 0. Also set SEED=0 → same first vector 32'h80200003.
- Mid-run reset: assert rst=0 while vec_count=500 in RAND → next cycle phase=0, dut_rst=1, dut_in=0, vec_count=0, no sample. A new start replays the sequence from 32'h80200003.
- Parameter corner (WIDTH=8, NUM_RANDOM=1, HOLD=1):
  - dut_in=8'h03, then 8'hAB in DIR.
  - busy lasts 6 cycles, sample pulses 4 times.
  - start pulsed while busy has no effect.
